vertical_skew_feeder: RTL
=========================

# vertical_skew_feeder

Writer-side front end of the vertical (column) data path. Accepts one row vector of COLS bytes per handshake from the tile loader and writes it diagonally skewed into the per-column vertical FIFOs: column c receives a row's byte c cycles after column 0. All columns advance in lockstep, so the diagonal wavefront the PE array expects is preserved under backpressure. Sits between the tile loader and the vertical buffer; drives its column write handshakes directly.

## Interface
- COLS, 16, number of PE columns / FIFOs
- DW, 8, data byte width per column
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- row_VALID  in  1  upstream row vector valid
- row_READY  out  1  block accepts row this cycle
- row_data  in  COLS*DW  row vector; byte c (bits c*DW+DW-1 : c*DW) goes to column c
- row_LAST  in  1  qualifies final row of a tile
- fifo_WREADY_col  in  COLS x 1  column FIFO can accept
- fifo_WVALID_col  out  COLS x 1  column write strobe
- in_col  out  COLS x DW  column write data
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse when tile fully written

## Operation
- Column c owns a delay line of c+1 registers, each a (valid, byte) pair; head = last stage.
- adv = AND over c of (!head_valid[c] | fifo_WREADY_col[c]). All lines shift one stage only when adv=1.
- fifo_WVALID_col[c] = head_valid[c] & adv; in_col[c] = head byte (0 when head invalid).
- WVALID depends combinationally on all WREADYs; legal because FIFO WREADY is registered. No column ever writes unless all occupied heads can write.
- On adv: stage 0 of every line loads (row_VALID & row_READY, byte c); a bubble (valid=0) loads otherwise.
- row_READY = adv & state != FLUSH & rst deasserted.
- FSM: IDLE -> STREAM on accept without row_LAST; IDLE/STREAM -> FLUSH on accept with row_LAST; FLUSH -> IDLE when flush counter reaches 0. STREAM stays while rows arrive; gaps insert bubbles.
- Flush counter: loaded with COLS on accepting row_LAST, decrements each adv in FLUSH; transition to IDLE and done pulse on the edge where it goes 1 -> 0 (that edge is the column COLS-1 write of the last row).
- Rows per tile unbounded; single-row tile (row_LAST on first row) legal.

## Timing
- Reset: all valids 0, state IDLE, counter 0; in_col 0, fifo_WVALID_col 0, row_READY 0 while rst low, busy 0, done 0.
- Unstalled: row accepted at edge t; column c WVALID high in cycle t+1+c, written at its closing edge.
- Throughput: one row per cycle with no stalls.
- Stall: any occupied head with WREADY=0 freezes every line and drops row_READY in the same cycle; data held stable.
- done: registered, high exactly one cycle after the last write; busy falls with it.
- Reset mid-tile: all in-flight bytes discarded, no further writes, no done pulse.

## Structure
- Package vsf_pkg: COLS, DW defaults, state enum typedef (IDLE, STREAM, FLUSH), flush counter width $clog2(COLS+1).
- Sub-module skew_line (parameter DEPTH, DW): shift-enabled valid/data delay line; instantiated per column via generate with DEPTH=c+1.
- Top holds adv logic, FSM, flush counter.

## Test plan
- Single row 0x0F..0x00 with row_LAST, all ready -> column c written byte c at cycle t+1+c, done pulse at t+17, exactly 16 writes total.
- Four back-to-back rows, last on row 3 -> column 5 receives rows 0..3 on consecutive cycles t+6..t+9; done at t+20.
- Column 7 WREADY low for 3 cycles mid-stream -> all WVALID and row_READY low those 3 cycles, no write lost or duplicated, done delayed by 3.
- Upstream gap of 2 cycles between rows -> 2-cycle bubble diagonally in every column, order preserved.
- rst low during FLUSH with 8 bytes in flight -> all outputs to reset values asynchronously, no done, next tile after reset clean.
- row_LAST tile followed immediately by new row -> row_READY 0 through FLUSH, new row accepted first cycle in IDLE.

Source files
------------

// File: rtl/vertical_skew_feeder_pkg.sv
// vsf_pkg: shared defaults, FSM state type and counter sizing for the vertical skew feeder.
package vsf_pkg;
    localparam int COLS_DEF = 16;
    localparam int DW_DEF   = 8;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;

    function automatic int cnt_width(input int cols);
        return $clog2(cols + 1);
    endfunction
endpackage

// File: rtl/vertical_skew_feeder_skew_line.sv
// skew_line: shift-enabled (valid, byte) delay line; the last stage is the column head.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);
    logic [DEPTH-1:0]         v_q;
    logic [DEPTH-1:0][DW-1:0] d_q;

    // Bubbles carry a zero byte so the head reads 0 whenever it is invalid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q <= '0;
            d_q <= '0;
        end else if (en_i) begin
            v_q[0] <= valid_i;
            d_q[0] <= valid_i ? data_i : '0;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end

    assign valid_o = v_q[DEPTH-1];
    assign data_o  = d_q[DEPTH-1];
endmodule

// File: rtl/vertical_skew_feeder.sv
// vertical_skew_feeder: writes row vectors diagonally skewed into per-column FIFOs,
// all columns advancing in lockstep so the wavefront survives backpressure.
module vertical_skew_feeder
    import vsf_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     row_valid_i,
    output logic                     row_ready_o,
    input  logic [COLS*DW-1:0]       row_data_i,
    input  logic                     row_last_i,
    input  logic [COLS-1:0]          fifo_wready_i,
    output logic [COLS-1:0]          fifo_wvalid_o,
    output logic [COLS-1:0][DW-1:0]  in_col_o,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int CNT_W = cnt_width(COLS);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic [COLS-1:0]  head_v;
    logic             adv;
    logic             accept;

    // Every occupied head must be writable before any column moves.
    assign adv           = &(~head_v | fifo_wready_i);
    assign row_ready_o   = adv & (state_q != FLUSH) & rst_ni;
    assign accept        = row_valid_i & row_ready_o;
    assign fifo_wvalid_o = head_v & {COLS{adv}};
    assign busy_o        = state_q != IDLE;
    assign done_o        = done_q;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        skew_line #(.DEPTH(c + 1), .DW(DW)) u_line (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .en_i    (adv),
            .valid_i (accept),
            .data_i  (row_data_i[c*DW +: DW]),
            .valid_o (head_v[c]),
            .data_o  (in_col_o[c])
        );
    end

    // The counter hits zero on the edge that writes the last row into the last column.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == FLUSH) begin
                if (adv) begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
            end else if (accept) begin
                state_q <= row_last_i ? FLUSH : STREAM;
                if (row_last_i) cnt_q <= CNT_W'(COLS);
            end
        end
    end
endmodule
